// File: rtl/keypad_pkg.sv
// keypad_pkg: shared FSM state type, matrix geometry and column-priority helper for the keypad scanner.
package keypad_pkg;
  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;
  localparam int ROW_W    = $clog2(NUM_ROWS);
  localparam int COL_W    = $clog2(NUM_COLS);
  typedef enum logic [1:0] {SCAN, DEBOUNCE, PRESSED, RELEASE} state_e;
  // Index of the lowest active-low column; the lowest index wins when several are low.
  function automatic logic [COL_W-1:0] lowest_low(input logic [NUM_COLS-1:0] col);
    lowest_low = '0;
    for (int i = NUM_COLS - 1; i >= 0; i--)
      if (!col[i]) lowest_low = COL_W'(i);
  endfunction
endpackage

// File: rtl/keypad_sync.sv
// keypad_sync: parameterized-width 2-flop synchronizer with a configurable reset value.
module keypad_sync #(
  parameter int           W       = 4,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta_q, sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  assign q = sync_q;
endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix scanner with tick-based debounce; define KEY_REPEAT_EN for auto-repeat while held.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_TICKS = 500,
  parameter int REPEAT_TICKS   = 25000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                scan_tick,
  input  logic [NUM_COLS-1:0] col_in,
  output logic [NUM_ROWS-1:0] row_out,
  output logic [CODE_W-1:0]   key_code,
  output logic                key_valid,
  output logic                key_held
);
  localparam int CNT_MAX = (DEBOUNCE_TICKS > REPEAT_TICKS) ? DEBOUNCE_TICKS : REPEAT_TICKS;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
`ifdef KEY_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_TICKS - 1);
`endif
  state_e               state_q, state_d;
  logic [ROW_W-1:0]     row_q, row_d;
  logic [NUM_COLS-1:0]  pat_q, pat_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
  logic [CODE_W-1:0]    code_q, code_d;
  logic                 valid_q, valid_d, held_q, held_d;
  logic [NUM_COLS-1:0]  col_s;
  logic                 pressed, stable, accept, rpt, rel_done;
  // Released columns idle high, so the synchronizer resets to all-ones.
  keypad_sync #(.W(NUM_COLS), .RST_VAL('1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (col_in),
    .q   (col_s)
  );
  assign pressed  = col_s != '1;
  assign stable   = col_s == pat_q;
  assign cnt_inc  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
  assign accept   = scan_tick && state_q == DEBOUNCE && stable && cnt_q == DEB_LAST;
  assign rel_done = !pressed && cnt_q == DEB_LAST;
`ifdef KEY_REPEAT_EN
  assign rpt = scan_tick && state_q == PRESSED && pressed && cnt_q == REP_LAST;
`else
  assign rpt = 1'b0;
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= SCAN;
      row_q   <= '0;
      pat_q   <= '1;
      cnt_q   <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      held_q  <= held_d;
    end
  always_comb begin
    state_d = state_q;
    if (scan_tick)
      case (state_q)
        SCAN:     state_d = pressed ? DEBOUNCE : SCAN;
        DEBOUNCE: state_d = !stable ? SCAN : (cnt_q == DEB_LAST) ? PRESSED : DEBOUNCE;
        PRESSED:  state_d = pressed ? PRESSED : RELEASE;
        RELEASE:  state_d = pressed ? PRESSED : rel_done ? SCAN : RELEASE;
      endcase
  end
  always_comb begin
    row_d   = row_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
    if (scan_tick)
      case (state_q)
        SCAN: begin
          row_d = pressed ? row_q : row_q + 1'b1;
          pat_d = pressed ? col_s : pat_q;
          cnt_d = '0;
        end
        DEBOUNCE: begin
          cnt_d   = (stable && !accept) ? cnt_inc : '0;
          code_d  = accept ? {row_q, lowest_low(pat_q)} : code_q;
          valid_d = accept;
          held_d  = held_q | accept;
        end
        PRESSED: begin
          cnt_d   = (!pressed || rpt) ? '0 : cnt_inc;
          valid_d = rpt;
        end
        RELEASE: begin
          cnt_d  = pressed ? '0 : cnt_inc;
          row_d  = rel_done ? row_q + 1'b1 : row_q;
          held_d = !rel_done;
        end
      endcase
  end
  assign row_out   = ~(NUM_ROWS'(1) << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scoreboard bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;
  logic        clk = 1'b0, rst = 1'b1, scan_tick = 1'b0;
  logic [3:0]  col_in, row_out, key_code;
  logic        key_valid, key_held;
  logic [15:0] key_mask = '0;
  logic [3:0]  exp_q[$];
  int          checks = 0, errors = 0;

  keypad_scanner #(.DEBOUNCE_TICKS(4), .REPEAT_TICKS(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .scan_tick (scan_tick),
    .col_in    (col_in),
    .row_out   (row_out),
    .key_code  (key_code),
    .key_valid (key_valid),
    .key_held  (key_held)
  );

  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!row_out[r] && key_mask[r*4+c]) col_in[c] = 1'b0;
  end

  initial forever begin
    repeat (9) @(posedge clk);
    #2 scan_tick = 1'b1;
    @(posedge clk);
    #2 scan_tick = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Returns at the falling edge just after a tick has been consumed.
  task automatic next_tick();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!scan_tick && n < 30);
    @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) next_tick();
  endtask

  task automatic wait_row(input logic [3:0] r);
    int n = 0;
    while (row_out !== r && n < 8) begin
      next_tick();
      n++;
    end
    check("wait_row", row_out, r);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_row_out"}, row_out, 4'b1110);
    check({tag, "_key_code"}, key_code, 4'h0);
    check({tag, "_key_valid"}, key_valid, 1'b0);
    check({tag, "_key_held"}, key_held, 1'b0);
  endtask

  initial fork
    forever begin
      @(negedge clk);
      if (!rst && key_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_key_valid: got code %0h expected no pulse", key_code);
        end else check("key_code_on_valid", key_code, exp_q.pop_front());
      end
    end
    begin
      #1_000_000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
    end
    begin
      logic [3:0] er;
      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      next_tick();
      rst = 1'b0;
      check("idle_row0", row_out, 4'b1110);
      for (int i = 1; i <= 20; i++) begin
        next_tick();
        er = ~(4'b0001 << (i % 4));
        check("idle_rotate", row_out, er);
      end
      // key 9: row2/col1
      key_mask[9] = 1'b1;
      exp_q.push_back(4'd9);
      ticks(10);
      check("k9_held", key_held, 1'b1);
      check("k9_code", key_code, 4'd9);
      check("k9_pending", exp_q.size(), 0);
      key_mask = '0;
      ticks(4);
      check("k9_held_in_release", key_held, 1'b1);
      next_tick();
      check("k9_released", key_held, 1'b0);
      check("k9_resume_row3", row_out, 4'b0111);
      // bounce on row0/col3 for two ticks
      wait_row(4'b1110);
      key_mask[3] = 1'b1;
      ticks(2);
      check("bounce_row_frozen", row_out, 4'b1110);
      check("bounce_held", key_held, 1'b0);
      key_mask = '0;
      ticks(2);
      check("bounce_back_to_scan", row_out, 4'b1101);
      // row1 with col0 and col2 low
      key_mask[4] = 1'b1;
      key_mask[6] = 1'b1;
      exp_q.push_back(4'd4);
      ticks(10);
      check("multi_held", key_held, 1'b1);
      check("multi_code", key_code, 4'd4);
      check("multi_pending", exp_q.size(), 0);
      key_mask = '0;
      ticks(6);
      check("multi_released", key_held, 1'b0);
      // reset two ticks into a debounce of key 1
      wait_row(4'b1110);
      key_mask[1] = 1'b1;
      ticks(2);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("midrst");
      next_tick();
      rst = 1'b0;
      ticks(4);
      check("midrst_no_early_key", key_held, 1'b0);
      exp_q.push_back(4'd1);
      next_tick();
      @(negedge clk);
      check("midrst_held", key_held, 1'b1);
      check("midrst_code", key_code, 4'd1);
      check("midrst_pending", exp_q.size(), 0);
      key_mask = '0;
      ticks(6);
      check("midrst_released", key_held, 1'b0);
      // key 9 held for 30 ticks
      wait_row(4'b1011);
      key_mask[9] = 1'b1;
`ifdef KEY_REPEAT_EN
      repeat (4) exp_q.push_back(4'd9);
`else
      exp_q.push_back(4'd9);
`endif
      ticks(30);
      key_mask = '0;
      ticks(6);
      @(negedge clk);
      check("hold30_pending", exp_q.size(), 0);
      check("hold30_released", key_held, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  join
endmodule
